// File: rtl/gzip_job_sequencer.sv
// rtl/gzip_job_sequencer.sv - one-job-at-a-time sequencer between the register block and the Deflate core
//
// Purpose:
//   Pops a job descriptor, holds the Deflate core in reset for RST_CYCLES while
//   presenting the job's btype/endianness, releases it, then waits for the core
//   to report done and for the final output word to leave through the output
//   FIFO. A completion record (id, status, ISIZE, CRC32, output bit count) is
//   presented until software accepts it. A watchdog bounds each job.
//
// Ports:
//   i_core_clock / i_bus_reset        clock, synchronous active-high reset
//   i_desc_*  / o_desc_ready          job descriptor queue (valid & ready = pop)
//   i_timeout_cycles                  watchdog limit, 0 disables, latched at pop
//   i_irq_enable                      gates o_irq
//   o_core_rst_n/btype/rev_endian     Deflate core control
//   i_core_done/btype_err/bsize_err   core status (done is a level)
//   i_core_isize/crc32/out_bits       core results, captured at done
//   i_out_last_beat                   pulse when the tlast word is accepted downstream
//   o_cpl_* / i_cpl_ready             completion record handshake
//   o_busy                            a job is in flight or awaiting acceptance
//   o_irq                             completion pending and interrupts enabled

module gzip_job_sequencer #(
    parameter int RST_CYCLES = 16,
    parameter int TMO_WIDTH  = 32,
    parameter int JOB_ID_W   = 8
) (
    input  logic                 i_core_clock,
    input  logic                 i_bus_reset,

    input  logic                 i_desc_valid,
    output logic                 o_desc_ready,
    input  logic [JOB_ID_W-1:0]  i_desc_id,
    input  logic [1:0]           i_desc_btype,
    input  logic                 i_desc_rev_endian,
    input  logic [TMO_WIDTH-1:0] i_timeout_cycles,
    input  logic                 i_irq_enable,

    output logic                 o_core_rst_n,
    output logic [1:0]           o_core_btype,
    output logic                 o_core_rev_endian,
    input  logic                 i_core_done,
    input  logic                 i_core_btype_err,
    input  logic                 i_core_bsize_err,
    input  logic [31:0]          i_core_isize,
    input  logic [31:0]          i_core_crc32,
    input  logic [23:0]          i_core_out_bits,
    input  logic                 i_out_last_beat,

    output logic                 o_cpl_valid,
    input  logic                 i_cpl_ready,
    output logic [JOB_ID_W-1:0]  o_cpl_id,
    output logic [2:0]           o_cpl_status,
    output logic [31:0]          o_cpl_isize,
    output logic [31:0]          o_cpl_crc32,
    output logic [23:0]          o_cpl_out_bits,
    output logic                 o_busy,
    output logic                 o_irq
);

    localparam int RCW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t               r_state;
    logic                 r_desc_ready;
    logic                 r_core_rst_n;
    logic [1:0]           r_core_btype;
    logic                 r_core_rev_endian;
    logic                 r_cpl_valid;
    logic [JOB_ID_W-1:0]  r_cpl_id;
    logic [2:0]           r_cpl_status;
    logic [31:0]          r_cpl_isize;
    logic [31:0]          r_cpl_crc32;
    logic [23:0]          r_cpl_out_bits;
    logic [TMO_WIDTH-1:0] r_tmo;
    logic [TMO_WIDTH-1:0] r_wdog;
    logic [RCW-1:0]       r_rst_cnt;
    logic                 r_last_seen;

    logic                 w_pop;
    logic [TMO_WIDTH-1:0] w_wdog_next;
    logic                 w_timeout;
    logic                 w_last;

    // r_desc_ready is only ever high in IDLE, so this is the pop condition.
    assign w_pop       = i_desc_valid & r_desc_ready;

    // The watchdog value after this cycle is compared, so a limit of N expires
    // on the N-th RUN/DRAIN cycle.
    assign w_wdog_next = r_wdog + TMO_WIDTH'(1);
    assign w_timeout   = (r_tmo != '0) && (w_wdog_next == r_tmo);

    // The tlast beat may land in the same cycle as done; treat it as already seen.
    assign w_last      = r_last_seen | i_out_last_beat;

    always_ff @(posedge i_core_clock) begin
        if (i_bus_reset) begin
            r_state           <= S_IDLE;
            r_desc_ready      <= 1'b0;
            r_core_rst_n      <= 1'b0;
            r_core_btype      <= 2'b00;
            r_core_rev_endian <= 1'b0;
            r_cpl_valid       <= 1'b0;
            r_cpl_id          <= '0;
            r_cpl_status      <= 3'b000;
            r_cpl_isize       <= 32'd0;
            r_cpl_crc32       <= 32'd0;
            r_cpl_out_bits    <= 24'd0;
            r_tmo             <= '0;
            r_wdog            <= '0;
            r_rst_cnt         <= '0;
            r_last_seen       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_desc_ready   <= 1'b0;
                        r_cpl_id       <= i_desc_id;
                        // Results default to zero so an expired job reports zeros.
                        r_cpl_isize    <= 32'd0;
                        r_cpl_crc32    <= 32'd0;
                        r_cpl_out_bits <= 24'd0;
                        r_tmo          <= i_timeout_cycles;
                        r_wdog         <= '0;
                        r_last_seen    <= 1'b0;
                        if (i_desc_btype[1]) begin
                            // Unsupported mode: complete immediately, leave the core alone.
                            r_cpl_status <= 3'b010;
                            r_cpl_valid  <= 1'b1;
                            r_state      <= S_REPORT;
                        end else begin
                            r_cpl_status      <= 3'b000;
                            r_core_btype      <= i_desc_btype;
                            r_core_rev_endian <= i_desc_rev_endian;
                            r_core_rst_n      <= 1'b0;
                            r_rst_cnt         <= '0;
                            r_state           <= S_RESET;
                        end
                    end else begin
                        // Raised one cycle after entering IDLE, which enforces
                        // a gap between a completion and the next pop.
                        r_desc_ready <= 1'b1;
                    end
                end

                S_RESET: begin
                    if (r_rst_cnt == RCW'(RST_CYCLES - 1)) begin
                        r_core_rst_n <= 1'b1;
                        r_wdog       <= '0;
                        r_state      <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end

                S_RUN: begin
                    r_wdog <= w_wdog_next;
                    if (i_out_last_beat) begin
                        r_last_seen <= 1'b1;
                    end
                    // Done takes priority over a watchdog expiring in the same cycle.
                    if (i_core_done) begin
                        r_cpl_isize    <= i_core_isize;
                        r_cpl_crc32    <= i_core_crc32;
                        r_cpl_out_bits <= i_core_out_bits;
                        r_cpl_status   <= {1'b0, i_core_btype_err, i_core_bsize_err};
                        if (w_last) begin
                            r_core_rst_n <= 1'b0;
                            r_cpl_valid  <= 1'b1;
                            r_state      <= S_REPORT;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_timeout) begin
                        r_cpl_status <= 3'b100;
                        r_core_rst_n <= 1'b0;
                        r_cpl_valid  <= 1'b1;
                        r_state      <= S_REPORT;
                    end
                end

                S_DRAIN: begin
                    r_wdog <= w_wdog_next;
                    if (w_last) begin
                        r_core_rst_n <= 1'b0;
                        r_cpl_valid  <= 1'b1;
                        r_state      <= S_REPORT;
                    end else if (w_timeout) begin
                        // Results were captured at done; only flag the timeout.
                        r_cpl_status[2] <= 1'b1;
                        r_core_rst_n    <= 1'b0;
                        r_cpl_valid     <= 1'b1;
                        r_state         <= S_REPORT;
                    end
                end

                S_REPORT: begin
                    if (i_cpl_ready) begin
                        r_cpl_valid  <= 1'b0;
                        r_core_rst_n <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_desc_ready      = r_desc_ready;
    assign o_core_rst_n      = r_core_rst_n;
    assign o_core_btype      = r_core_btype;
    assign o_core_rev_endian = r_core_rev_endian;
    assign o_cpl_valid       = r_cpl_valid;
    assign o_cpl_id          = r_cpl_id;
    assign o_cpl_status      = r_cpl_status;
    assign o_cpl_isize       = r_cpl_isize;
    assign o_cpl_crc32       = r_cpl_crc32;
    assign o_cpl_out_bits    = r_cpl_out_bits;
    assign o_busy            = (r_state != S_IDLE);
    assign o_irq             = r_cpl_valid & i_irq_enable;

endmodule
